// File: rtl/bus_pkg.sv
// Shared widths and 5-bit source codes for the CPU datapath bus.
package bus_pkg;
   localparam int WIDTH = 32;
   localparam int NSRC  = 24;

   localparam logic [4:0] SRC_R0   = 5'd0;
   localparam logic [4:0] SRC_R1   = 5'd1;
   localparam logic [4:0] SRC_R2   = 5'd2;
   localparam logic [4:0] SRC_R3   = 5'd3;
   localparam logic [4:0] SRC_R4   = 5'd4;
   localparam logic [4:0] SRC_R5   = 5'd5;
   localparam logic [4:0] SRC_R6   = 5'd6;
   localparam logic [4:0] SRC_R7   = 5'd7;
   localparam logic [4:0] SRC_R8   = 5'd8;
   localparam logic [4:0] SRC_R9   = 5'd9;
   localparam logic [4:0] SRC_R10  = 5'd10;
   localparam logic [4:0] SRC_R11  = 5'd11;
   localparam logic [4:0] SRC_R12  = 5'd12;
   localparam logic [4:0] SRC_R13  = 5'd13;
   localparam logic [4:0] SRC_R14  = 5'd14;
   localparam logic [4:0] SRC_R15  = 5'd15;
   localparam logic [4:0] SRC_HI   = 5'd16;
   localparam logic [4:0] SRC_LO   = 5'd17;
   localparam logic [4:0] SRC_ZHI  = 5'd18;
   localparam logic [4:0] SRC_ZLO  = 5'd19;
   localparam logic [4:0] SRC_PC   = 5'd20;
   localparam logic [4:0] SRC_MDR  = 5'd21;
   localparam logic [4:0] SRC_PORT = 5'd22;
   localparam logic [4:0] SRC_C    = 5'd23;
endpackage

// File: rtl/bus_encoder_32to5.sv
// Priority encoder: lowest set bit of a 32-bit enable vector -> 5-bit code + valid.
module bus_encoder_32to5 (
   input  logic [31:0] en_i,
   output logic [4:0]  code_o,
   output logic        valid_o
);
   // Scan from the top so the lowest set bit is the last (winning) assignment.
   always_comb begin
      code_o  = 5'd0;
      valid_o = 1'b0;
      for (int i = 31; i >= 0; i--) begin
         if (en_i[i]) begin
            code_o  = 5'(i);
            valid_o = 1'b1;
         end
      end
   end
endmodule

// File: rtl/bus.sv
// CPU datapath bus: priority-selects one of 24 sources onto BusMuxOut, zeroed by clear.
module bus
   import bus_pkg::*;
(
   input  logic [WIDTH-1:0] BusMuxR0In,  BusMuxR1In,  BusMuxR2In,  BusMuxR3In,
   input  logic [WIDTH-1:0] BusMuxR4In,  BusMuxR5In,  BusMuxR6In,  BusMuxR7In,
   input  logic [WIDTH-1:0] BusMuxR8In,  BusMuxR9In,  BusMuxR10In, BusMuxR11In,
   input  logic [WIDTH-1:0] BusMuxR12In, BusMuxR13In, BusMuxR14In, BusMuxR15In,
   input  logic [WIDTH-1:0] BusMuxHIIn,  BusMuxLOIn,  BusMuxZhighIn, BusMuxZlowIn,
   input  logic [WIDTH-1:0] BusMuxPCIn,  BusMuxMDRIn, BusMuxPortIn,  C_sign_extended,
   input  logic             R0out,  R1out,  R2out,  R3out,  R4out,  R5out,  R6out,  R7out,
   input  logic             R8out,  R9out,  R10out, R11out, R12out, R13out, R14out, R15out,
   input  logic             HIout,  LOout,  Zhighout, Zlowout, PCout, MDRout, Portout, Cout,
   input  logic             clk,
   output logic [WIDTH-1:0] BusMuxOut,
   input  logic             clear
);
   logic [31:0]      en;
   logic [4:0]       sel;
   logic             sel_vld;
   logic [WIDTH-1:0] mux_out;

   // clk is carried only for port uniformity with the rest of the control path.
   logic unused_clk;
   assign unused_clk = clk;

   assign en = {8'h00,
                Cout, Portout, MDRout, PCout, Zlowout, Zhighout, LOout, HIout,
                R15out, R14out, R13out, R12out, R11out, R10out, R9out, R8out,
                R7out,  R6out,  R5out,  R4out,  R3out,  R2out,  R1out, R0out};

   bus_encoder_32to5 u_enc (
      .en_i    (en),
      .code_o  (sel),
      .valid_o (sel_vld)
   );

   always_comb begin
      mux_out = '0;
      case (sel)
         SRC_R0:   mux_out = BusMuxR0In;
         SRC_R1:   mux_out = BusMuxR1In;
         SRC_R2:   mux_out = BusMuxR2In;
         SRC_R3:   mux_out = BusMuxR3In;
         SRC_R4:   mux_out = BusMuxR4In;
         SRC_R5:   mux_out = BusMuxR5In;
         SRC_R6:   mux_out = BusMuxR6In;
         SRC_R7:   mux_out = BusMuxR7In;
         SRC_R8:   mux_out = BusMuxR8In;
         SRC_R9:   mux_out = BusMuxR9In;
         SRC_R10:  mux_out = BusMuxR10In;
         SRC_R11:  mux_out = BusMuxR11In;
         SRC_R12:  mux_out = BusMuxR12In;
         SRC_R13:  mux_out = BusMuxR13In;
         SRC_R14:  mux_out = BusMuxR14In;
         SRC_R15:  mux_out = BusMuxR15In;
         SRC_HI:   mux_out = BusMuxHIIn;
         SRC_LO:   mux_out = BusMuxLOIn;
         SRC_ZHI:  mux_out = BusMuxZhighIn;
         SRC_ZLO:  mux_out = BusMuxZlowIn;
         SRC_PC:   mux_out = BusMuxPCIn;
         SRC_MDR:  mux_out = BusMuxMDRIn;
         SRC_PORT: mux_out = BusMuxPortIn;
         SRC_C:    mux_out = C_sign_extended;
         default:  mux_out = '0;
      endcase
   end

   // No enable, or clear asserted, puts zero on the bus without waiting for a clock.
   assign BusMuxOut = (clear && sel_vld) ? mux_out : '0;
endmodule

// File: tb/tb_bus.sv
// Directed bench for bus: stimulus queues expected bus values, a monitor pops and compares.
module tb_bus;
   typedef struct {
      string       name;
      logic [31:0] val;
   } exp_t;

   logic        clk = 1'b0;
   logic        clear = 1'b0;
   logic [31:0] din [24];
   logic [23:0] en = '0;
   logic [31:0] bus_out;
   logic        smp = 1'b0;
   exp_t        exp_q[$];
   int          total = 0;
   int          bad = 0;

   always #5 clk = ~clk;

   bus dut (
      .BusMuxR0In(din[0]),   .BusMuxR1In(din[1]),   .BusMuxR2In(din[2]),   .BusMuxR3In(din[3]),
      .BusMuxR4In(din[4]),   .BusMuxR5In(din[5]),   .BusMuxR6In(din[6]),   .BusMuxR7In(din[7]),
      .BusMuxR8In(din[8]),   .BusMuxR9In(din[9]),   .BusMuxR10In(din[10]), .BusMuxR11In(din[11]),
      .BusMuxR12In(din[12]), .BusMuxR13In(din[13]), .BusMuxR14In(din[14]), .BusMuxR15In(din[15]),
      .BusMuxHIIn(din[16]),  .BusMuxLOIn(din[17]),  .BusMuxZhighIn(din[18]), .BusMuxZlowIn(din[19]),
      .BusMuxPCIn(din[20]),  .BusMuxMDRIn(din[21]), .BusMuxPortIn(din[22]),  .C_sign_extended(din[23]),
      .R0out(en[0]),   .R1out(en[1]),   .R2out(en[2]),   .R3out(en[3]),
      .R4out(en[4]),   .R5out(en[5]),   .R6out(en[6]),   .R7out(en[7]),
      .R8out(en[8]),   .R9out(en[9]),   .R10out(en[10]), .R11out(en[11]),
      .R12out(en[12]), .R13out(en[13]), .R14out(en[14]), .R15out(en[15]),
      .HIout(en[16]),  .LOout(en[17]),  .Zhighout(en[18]), .Zlowout(en[19]),
      .PCout(en[20]),  .MDRout(en[21]), .Portout(en[22]),  .Cout(en[23]),
      .clk(clk),
      .BusMuxOut(bus_out),
      .clear(clear)
   );

   // Monitor: each strobe means the bus has settled on the value at the head of the queue.
   always @(posedge smp) begin
      exp_t e;
      total++;
      if (exp_q.size() == 0) begin
         bad++;
         $display("FAIL unexpected_sample got=%08h expected=<none>", bus_out);
      end else begin
         e = exp_q.pop_front();
         if (bus_out !== e.val) begin
            bad++;
            $display("FAIL %s got=%08h expected=%08h", e.name, bus_out, e.val);
         end
      end
   end

   task automatic expect_bus(input string nm, input logic [31:0] v);
      exp_t e;
      #1;
      e.name = nm;
      e.val  = v;
      exp_q.push_back(e);
      smp = 1'b1;
      #1;
      smp = 1'b0;
      #1;
   endtask

   initial begin
      for (int i = 0; i < 24; i++) din[i] = '0;
      din[1] = 32'h0000_1111;
      en[1]  = 1'b1;
      clear  = 1'b0;
      expect_bus("reset_zero", 32'h0);

      @(negedge clk);
      clear = 1'b1;
      en    = '0;
      expect_bus("no_enable", 32'h0);

      en[1] = 1'b1;
      expect_bus("r1_select", 32'h0000_1111);
      en[1] = 1'b0;
      expect_bus("r1_release", 32'h0);

      din[2] = 32'h1111_0000;
      en[1]  = 1'b1;
      en[2]  = 1'b1;
      expect_bus("prio_r1_r2", 32'h0000_1111);
      en[1]  = 1'b0;
      expect_bus("r2_only", 32'h1111_0000);

      for (int k = 0; k < 24; k++) din[k] = 32'hA500_0000 | 32'(k);
      for (int k = 0; k < 24; k++) begin
         en = 24'(1) << k;
         expect_bus($sformatf("walk_%0d", k), 32'hA500_0000 | 32'(k));
      end

      en = '1;
      expect_bus("all_enables_r0", 32'hA500_0000);

      din[23] = 32'hFFFF_FFF6;
      en      = 24'(1) << 23;
      expect_bus("cout_sext", 32'hFFFF_FFF6);
      en[18]  = 1'b1;
      expect_bus("prio_zhi_c", 32'hA500_0012);

      @(negedge clk);
      din[20] = 32'h0000_0040;
      en      = 24'(1) << 20;
      expect_bus("pc_select", 32'h0000_0040);
      #2;
      clear = 1'b0;
      expect_bus("clear_async", 32'h0);
      clear = 1'b1;
      expect_bus("clear_release", 32'h0000_0040);

      #5;
      if (exp_q.size() != 0) begin
         total++;
         bad++;
         $display("FAIL pending_expectations left=%0d required=0", exp_q.size());
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
